inta_sequencer: RTL and testbench

- Interrupt-acknowledge sequencer for the PIC, directly upstream of the cascade block.
- Resolves the highest-priority pending request and raises INT.
- Runs the two-pulse 8086-mode INTA cycle and owns the in-service register. Its `isr` output feeds the cascade block.
- Consumes the cascade block's `send_vector_address` to decide whether this device drives the vector byte on the second INTA.

---
 rtl/inta_sequencer_if.sv | 40 ++++
 rtl/inta_sequencer.sv | 163 ++++++++++++++++
 tb/tb_inta_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - acknowledge/bus bundle between the CPU-side environment and inta_sequencer
//
// Signals:
//   INTA_N               CPU acknowledge pin, active-low, asynchronous to clk
//   irr[7:0]             latched interrupt requests (bit n = IRn)
//   imr[7:0]             mask register, 1 = masked
//   icw2[7:0]            vector base, bits [7:3] used
//   aeoi                 auto-EOI mode
//   eoi                  one-cycle non-specific EOI pulse
//   send_vector_address  from cascade block, 1 = this device drives the vector
//   INT                  interrupt request to CPU
//   isr[7:0]             in-service register, feeds the cascade block
//   irr_clear[7:0]       one-cycle pulse clearing the acknowledged IRR bit
//   data_out[7:0]        vector byte
//   data_oe              data bus drive enable
// Modports: master drives the requests and INTA_N, slave is the sequencer.
interface inta_sequencer_if;
   logic       INTA_N;
   logic [7:0] irr;
   logic [7:0] imr;
   logic [7:0] icw2;
   logic       aeoi;
   logic       eoi;
   logic       send_vector_address;
   logic       INT;
   logic [7:0] isr;
   logic [7:0] irr_clear;
   logic [7:0] data_out;
   logic       data_oe;

   modport master (
      output INTA_N, irr, imr, icw2, aeoi, eoi, send_vector_address,
      input  INT, isr, irr_clear, data_out, data_oe
   );

   modport slave (
      input  INTA_N, irr, imr, icw2, aeoi, eoi, send_vector_address,
      output INT, isr, irr_clear, data_out, data_oe
   );
endinterface

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - PIC interrupt-acknowledge sequencer (priority, INT, 8086 two-pulse INTA, ISR)
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-high reset
//   bus   inta_sequencer_if.slave (INTA_N, irr, imr, icw2, aeoi, eoi,
//         send_vector_address in; INT, isr, irr_clear, data_out, data_oe out)
// Parameters:
//   SYNC_STAGES     flops in the INTA_N synchronizer (2..3)
//   TIMEOUT_CYCLES  GAP-state cycle budget, only with INTA_TIMEOUT_EN
// Optional feature macro: INTA_TIMEOUT_EN (GAP-state timeout counter).
module inta_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   inta_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   inta_prev;
   logic                   inta_cur;
   logic                   inta_fall;
   logic                   inta_rise;

   logic [7:0] pend;
   logic [2:0] win;
   logic [3:0] isr_top;
   logic       eligible;

   logic [7:0] isr_q;
   logic [7:0] isr_next;
   logic [7:0] set_mask;
   logic [7:0] aeoi_mask;
   logic [7:0] eoi_mask;
   logic [2:0] idx;
   logic       spurious;
   logic [7:0] irr_clear_q;
   logic [7:0] data_out_q;
   logic       data_oe_q;

`ifdef INTA_TIMEOUT_EN
   logic [7:0] tmo_cnt;
`else
   logic [7:0] unused_tmo;
   assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

   logic [2:0] unused_icw2;
   assign unused_icw2 = bus.icw2[2:0];

   // Synchronizer resets to 1 so a released pin never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '1;
         inta_prev <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.INTA_N};
         inta_prev <= inta_cur;
      end
   end

   assign inta_cur  = sync_q[SYNC_STAGES-1];
   assign inta_fall = inta_prev & ~inta_cur;
   assign inta_rise = ~inta_prev & inta_cur;

   // Fixed priority, IR0 highest: the lowest set index wins. isr_top is the
   // index of the highest-priority in-service level, 8 when nothing is in service.
   always_comb begin
      pend    = bus.irr & ~bus.imr;
      win     = 3'd0;
      isr_top = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         if (pend[i])  win     = 3'(i);
         if (isr_q[i]) isr_top = 4'(i);
      end
      eligible = (|pend) && ({1'b0, win} < isr_top);
   end

   // EOI acts on the pre-set isr value, the ACK1 set is OR-ed in last so it
   // always wins for its own bit. isr & -isr isolates the lowest set bit.
   always_comb begin
      set_mask  = (state == IDLE && inta_fall && eligible) ? (8'd1 << win) : 8'd0;
      aeoi_mask = (state == ACK2 && inta_rise && bus.aeoi && !spurious) ? (8'd1 << idx) : 8'd0;
      eoi_mask  = bus.eoi ? (isr_q & (~isr_q + 8'd1)) : 8'd0;
      isr_next  = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         isr_q       <= 8'h00;
         idx         <= 3'd0;
         spurious    <= 1'b0;
         irr_clear_q <= 8'h00;
         data_out_q  <= 8'h00;
         data_oe_q   <= 1'b0;
`ifdef INTA_TIMEOUT_EN
         tmo_cnt     <= 8'd0;
`endif
      end else begin
         isr_q       <= isr_next;
         irr_clear_q <= 8'h00;
         case (state)
            IDLE: begin
               // The first INTA is honoured even without INT; it then becomes a spurious ack.
               if (inta_fall) begin
                  state <= ACK1;
                  if (eligible) begin
                     idx         <= win;
                     spurious    <= 1'b0;
                     irr_clear_q <= 8'd1 << win;
                  end else begin
                     idx      <= 3'd7;
                     spurious <= 1'b1;
                  end
               end
            end
            ACK1: begin
               state <= GAP;
`ifdef INTA_TIMEOUT_EN
               tmo_cnt <= 8'(TIMEOUT_CYCLES);
`endif
            end
            GAP: begin
               // A falling edge can only follow a high level, so the release of
               // the first pulse needs no separate tracking.
               if (inta_fall) begin
                  state      <= ACK2;
                  data_out_q <= {bus.icw2[7:3], idx};
                  data_oe_q  <= bus.send_vector_address;
               end
`ifdef INTA_TIMEOUT_EN
               else if (tmo_cnt <= 8'd1) begin
                  state   <= IDLE;
                  tmo_cnt <= 8'd0;
               end else begin
                  tmo_cnt <= tmo_cnt - 8'd1;
               end
`endif
            end
            ACK2: begin
               if (inta_rise) begin
                  data_oe_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.INT       = (state == IDLE) && eligible;
   assign bus.isr       = isr_q;
   assign bus.irr_clear = irr_clear_q;
   assign bus.data_out  = data_out_q;
   assign bus.data_oe   = data_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - directed self-checking bench for inta_sequencer
module tb_inta_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   inta_sequencer_if bus ();

   inta_sequencer #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // INTA_N edge to FSM action is three clocks with a 2-flop synchronizer.
   task automatic pulse1();
      bus.INTA_N = 1'b0;
      step(3);
   endtask

   task automatic release_gap();
      bus.INTA_N = 1'b1;
      step(3);
   endtask

   task automatic pulse2();
      bus.INTA_N = 1'b0;
      step(3);
   endtask

   task automatic release2();
      bus.INTA_N = 1'b1;
      step(3);
   endtask

   task automatic eoi_pulse();
      bus.eoi = 1'b1;
      step(1);
      bus.eoi = 1'b0;
   endtask

   task automatic full_ack();
      pulse1();
      step(1);
      release_gap();
      pulse2();
      release2();
   endtask

   task automatic test_reset();
      bus.INTA_N = 1'b1;
      bus.irr = 8'h00;
      bus.imr = 8'h00;
      bus.icw2 = 8'h40;
      bus.aeoi = 1'b0;
      bus.eoi = 1'b0;
      bus.send_vector_address = 1'b1;
      rst = 1'b1;
      step(2);
      n_cmp++; if (bus.INT !== 1'b0) begin n_bad++; $display("FAIL reset_int: got %b want 0", bus.INT); end
      n_cmp++; if (bus.isr !== 8'h00) begin n_bad++; $display("FAIL reset_isr: got %h want 00", bus.isr); end
      n_cmp++; if (bus.irr_clear !== 8'h00) begin n_bad++; $display("FAIL reset_irr_clear: got %h want 00", bus.irr_clear); end
      n_cmp++; if (bus.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
      n_cmp++; if (bus.data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_data_oe: got %b want 0", bus.data_oe); end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_basic();
      bus.irr = 8'h08;
      bus.icw2 = 8'h40;
      bus.send_vector_address = 1'b1;
      bus.aeoi = 1'b0;
      step(1);
      n_cmp++; if (bus.INT !== 1'b1) begin n_bad++; $display("FAIL basic_int_high: got %b want 1", bus.INT); end
      pulse1();
      n_cmp++; if (bus.INT !== 1'b0) begin n_bad++; $display("FAIL basic_int_drop: got %b want 0", bus.INT); end
      n_cmp++; if (bus.irr_clear !== 8'h08) begin n_bad++; $display("FAIL basic_irr_clear: got %h want 08", bus.irr_clear); end
      n_cmp++; if (bus.isr !== 8'h08) begin n_bad++; $display("FAIL basic_isr_set: got %h want 08", bus.isr); end
      bus.irr = 8'h00;
      step(1);
      n_cmp++; if (bus.irr_clear !== 8'h00) begin n_bad++; $display("FAIL basic_irr_clear_once: got %h want 00", bus.irr_clear); end
      release_gap();
      pulse2();
      n_cmp++; if (bus.data_out !== 8'h43) begin n_bad++; $display("FAIL basic_vector: got %h want 43", bus.data_out); end
      n_cmp++; if (bus.data_oe !== 1'b1) begin n_bad++; $display("FAIL basic_data_oe: got %b want 1", bus.data_oe); end
      release2();
      n_cmp++; if (bus.data_oe !== 1'b0) begin n_bad++; $display("FAIL basic_data_oe_off: got %b want 0", bus.data_oe); end
      n_cmp++; if (bus.isr !== 8'h08) begin n_bad++; $display("FAIL basic_isr_kept: got %h want 08", bus.isr); end
      eoi_pulse();
      n_cmp++; if (bus.isr !== 8'h00) begin n_bad++; $display("FAIL basic_eoi: got %h want 00", bus.isr); end
   endtask

   task automatic test_nesting();
      bus.irr = 8'h04;
      full_ack();
      bus.irr = 8'h00;
      n_cmp++; if (bus.isr !== 8'h04) begin n_bad++; $display("FAIL nest_setup_isr: got %h want 04", bus.isr); end
      bus.irr = 8'h30;
      step(1);
      n_cmp++; if (bus.INT !== 1'b0) begin n_bad++; $display("FAIL nest_lower_blocked: got %b want 0", bus.INT); end
      bus.irr = 8'h03;
      step(1);
      n_cmp++; if (bus.INT !== 1'b1) begin n_bad++; $display("FAIL nest_higher_int: got %b want 1", bus.INT); end
      pulse1();
      n_cmp++; if (bus.isr !== 8'h05) begin n_bad++; $display("FAIL nest_isr: got %h want 05", bus.isr); end
      n_cmp++; if (bus.irr_clear !== 8'h01) begin n_bad++; $display("FAIL nest_irr_clear: got %h want 01", bus.irr_clear); end
      bus.irr = 8'h02;
      step(1);
      release_gap();
      pulse2();
      n_cmp++; if (bus.data_out !== 8'h40) begin n_bad++; $display("FAIL nest_vector: got %h want 40", bus.data_out); end
      release2();
      n_cmp++; if (bus.INT !== 1'b0) begin n_bad++; $display("FAIL nest_ir1_blocked: got %b want 0", bus.INT); end
      eoi_pulse();
      n_cmp++; if (bus.isr !== 8'h04) begin n_bad++; $display("FAIL nest_eoi_top: got %h want 04", bus.isr); end
      n_cmp++; if (bus.INT !== 1'b1) begin n_bad++; $display("FAIL nest_ir1_after_eoi: got %b want 1", bus.INT); end
      bus.irr = 8'h00;
      eoi_pulse();
      n_cmp++; if (bus.isr !== 8'h00) begin n_bad++; $display("FAIL nest_eoi_last: got %h want 00", bus.isr); end
   endtask

   task automatic test_aeoi();
      bus.aeoi = 1'b1;
      bus.send_vector_address = 1'b0;
      bus.irr = 8'h80;
      step(1);
      pulse1();
      n_cmp++; if (bus.isr !== 8'h80) begin n_bad++; $display("FAIL aeoi_isr_set: got %h want 80", bus.isr); end
      bus.irr = 8'h00;
      step(1);
      release_gap();
      pulse2();
      n_cmp++; if (bus.data_oe !== 1'b0) begin n_bad++; $display("FAIL aeoi_slave_off: got %b want 0", bus.data_oe); end
      n_cmp++; if (bus.isr !== 8'h80) begin n_bad++; $display("FAIL aeoi_isr_ack2: got %h want 80", bus.isr); end
      n_cmp++; if (bus.data_out !== 8'h47) begin n_bad++; $display("FAIL aeoi_vector: got %h want 47", bus.data_out); end
      release2();
      n_cmp++; if (bus.isr !== 8'h00) begin n_bad++; $display("FAIL aeoi_isr_cleared: got %h want 00", bus.isr); end
      bus.aeoi = 1'b0;
      bus.send_vector_address = 1'b1;
   endtask

   task automatic test_spurious();
      bus.irr = 8'h80;
      full_ack();
      bus.irr = 8'h00;
      bus.icw2 = 8'h88;
      bus.aeoi = 1'b1;
      step(1);
      pulse1();
      n_cmp++; if (bus.irr_clear !== 8'h00) begin n_bad++; $display("FAIL spur_no_clear: got %h want 00", bus.irr_clear); end
      n_cmp++; if (bus.isr !== 8'h80) begin n_bad++; $display("FAIL spur_isr_ack1: got %h want 80", bus.isr); end
      step(1);
      release_gap();
      pulse2();
      n_cmp++; if (bus.data_out !== 8'h8f) begin n_bad++; $display("FAIL spur_vector: got %h want 8f", bus.data_out); end
      n_cmp++; if (bus.data_oe !== 1'b1) begin n_bad++; $display("FAIL spur_data_oe: got %b want 1", bus.data_oe); end
      release2();
      n_cmp++; if (bus.isr !== 8'h80) begin n_bad++; $display("FAIL spur_isr_kept: got %h want 80", bus.isr); end
      bus.aeoi = 1'b0;
      bus.icw2 = 8'h40;
      eoi_pulse();
   endtask

   task automatic test_eoi_collision();
      bus.irr = 8'h02;
      full_ack();
      bus.irr = 8'h01;
      n_cmp++; if (bus.isr !== 8'h02) begin n_bad++; $display("FAIL coll_setup_isr: got %h want 02", bus.isr); end
      bus.INTA_N = 1'b0;
      step(2);
      bus.eoi = 1'b1;
      step(1);
      bus.eoi = 1'b0;
      n_cmp++; if (bus.isr !== 8'h01) begin n_bad++; $display("FAIL coll_isr: got %h want 01", bus.isr); end
      n_cmp++; if (bus.irr_clear !== 8'h01) begin n_bad++; $display("FAIL coll_irr_clear: got %h want 01", bus.irr_clear); end
      bus.irr = 8'h00;
      step(1);
      release_gap();
      pulse2();
      n_cmp++; if (bus.data_out !== 8'h40) begin n_bad++; $display("FAIL coll_vector: got %h want 40", bus.data_out); end
      release2();
      eoi_pulse();
   endtask

   task automatic test_reset_mid();
      bus.irr = 8'h08;
      bus.send_vector_address = 1'b1;
      step(1);
      pulse1();
      bus.irr = 8'h00;
      step(1);
      release_gap();
      pulse2();
      n_cmp++; if (bus.data_oe !== 1'b1) begin n_bad++; $display("FAIL rmid_data_oe_before: got %b want 1", bus.data_oe); end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.data_oe !== 1'b0) begin n_bad++; $display("FAIL rmid_data_oe_async: got %b want 0", bus.data_oe); end
      n_cmp++; if (bus.isr !== 8'h00) begin n_bad++; $display("FAIL rmid_isr: got %h want 00", bus.isr); end
      n_cmp++; if (bus.data_out !== 8'h00) begin n_bad++; $display("FAIL rmid_data_out: got %h want 00", bus.data_out); end
      step(2);
      bus.INTA_N = 1'b1;
      rst = 1'b0;
      step(3);
      bus.irr = 8'h08;
      step(1);
      n_cmp++; if (bus.INT !== 1'b1) begin n_bad++; $display("FAIL rmid_idle_int: got %b want 1", bus.INT); end
      bus.irr = 8'h00;
      step(1);
   endtask

`ifndef INTA_TIMEOUT_EN
   task automatic test_gap_wait();
      bus.irr = 8'h04;
      step(1);
      pulse1();
      bus.irr = 8'h01;
      step(1);
      release_gap();
      step(300);
      n_cmp++; if (bus.INT !== 1'b0) begin n_bad++; $display("FAIL gap_still_waiting: got %b want 0", bus.INT); end
      pulse2();
      n_cmp++; if (bus.data_out !== 8'h42) begin n_bad++; $display("FAIL gap_vector: got %h want 42", bus.data_out); end
      n_cmp++; if (bus.data_oe !== 1'b1) begin n_bad++; $display("FAIL gap_data_oe: got %b want 1", bus.data_oe); end
      release2();
      n_cmp++; if (bus.INT !== 1'b1) begin n_bad++; $display("FAIL gap_back_idle: got %b want 1", bus.INT); end
      bus.irr = 8'h00;
      eoi_pulse();
   endtask
`else
   task automatic test_timeout();
      bus.irr = 8'h08;
      step(1);
      pulse1();
      bus.irr = 8'h01;
      bus.INTA_N = 1'b1;
      step(4);
      n_cmp++; if (bus.INT !== 1'b0) begin n_bad++; $display("FAIL tmo_in_gap: got %b want 0", bus.INT); end
      step(1);
      n_cmp++; if (bus.INT !== 1'b1) begin n_bad++; $display("FAIL tmo_back_idle: got %b want 1", bus.INT); end
      n_cmp++; if (bus.data_oe !== 1'b0) begin n_bad++; $display("FAIL tmo_data_oe: got %b want 0", bus.data_oe); end
      n_cmp++; if (bus.isr !== 8'h08) begin n_bad++; $display("FAIL tmo_isr_kept: got %h want 08", bus.isr); end
      bus.irr = 8'h00;
      eoi_pulse();
      n_cmp++; if (bus.isr !== 8'h00) begin n_bad++; $display("FAIL tmo_eoi: got %h want 00", bus.isr); end
   endtask
`endif

   initial begin
      test_reset();
`ifndef INTA_TIMEOUT_EN
      test_basic();
      test_nesting();
      test_aeoi();
      test_spurious();
      test_eoi_collision();
      test_gap_wait();
      test_reset_mid();
`else
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
